stage2: RTL and testbench



---
 rtl/stage2.sv | 146 ++++++++++++++
 tb/tb_stage2.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage2.sv
// Second game stage: multi-round endurance challenge fed by stage1's verdict.
// Optional refund rounds are enabled by defining the macro STAGE2_REFUND_EN.
`timescale 1ns/1ps
module stage2 #(
  parameter int ROUNDS     = 8,
  parameter int BONUS_STEP = 16,
  parameter int COST_BITS  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic       i_pass1,
  input  logic [1:0] i_bonus1,
  input  logic [6:0] i_stamina,
  input  logic [6:0] i_random2,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic       o_pass2,
  output logic [1:0] o_bonus2,
  output logic [6:0] o_score,
  output logic [1:0] o_dbg_state
);

  localparam int CW = $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [6:0]    r_energy, w_energy_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_pass2, w_pass2_nxt;
  logic [1:0]    r_bonus2, w_bonus2_nxt;
  logic [6:0]    r_score, w_score_nxt;

  logic [6:0] w_cost;
  logic [8:0] w_start;
  logic [6:0] w_start_sat;
  logic [7:0] w_refund_sum;
  logic       w_is_refund;
  logic       w_fail;
  logic       w_last;
  logic [6:0] w_round_energy;
  logic       w_unused;

  function automatic logic [1:0] bonus_of(input logic [6:0] e);
    if (e >= 7'd96)      return 2'd3;
    else if (e >= 7'd64) return 2'd2;
    else if (e >= 7'd32) return 2'd1;
    else                 return 2'd0;
  endfunction

  assign w_cost       = 7'(i_random2[COST_BITS-1:0]);
  assign w_start      = 9'(i_stamina) + 9'(i_bonus1) * 9'(BONUS_STEP);
  assign w_start_sat  = (w_start > 9'd127) ? 7'd127 : w_start[6:0];
  assign w_refund_sum = 8'(r_energy) + 8'(w_cost);
`ifdef STAGE2_REFUND_EN
  assign w_is_refund  = i_random2[6];
`else
  assign w_is_refund  = 1'b0;
`endif
  assign w_unused       = &{1'b0, i_random2};
  assign w_fail         = !w_is_refund && (w_cost > r_energy);
  assign w_last         = (r_cnt == CW'(ROUNDS - 1));
  assign w_round_energy = w_is_refund ? ((w_refund_sum > 8'd127) ? 7'd127 : w_refund_sum[6:0])
                                      : (r_energy - w_cost);

  // Handshakes: a transfer happens on an edge where valid && ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and DONE outputs hold until taken.
  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_DONE);
  assign o_pass2     = r_pass2;
  assign o_bonus2    = r_bonus2;
  assign o_score     = r_score;
  assign o_dbg_state = r_state;

  always_comb begin
    w_state_nxt  = r_state;
    w_energy_nxt = r_energy;
    w_cnt_nxt    = r_cnt;
    w_pass2_nxt  = r_pass2;
    w_bonus2_nxt = r_bonus2;
    w_score_nxt  = r_score;
    case (r_state)
      S_IDLE: begin
        if (i_in_valid) begin
          if (i_pass1) begin
            w_energy_nxt = w_start_sat;
            w_cnt_nxt    = '0;
            w_state_nxt  = S_RUN;
          end else begin
            w_pass2_nxt  = 1'b0;
            w_bonus2_nxt = 2'd0;
            w_score_nxt  = 7'd0;
            w_state_nxt  = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (w_fail) begin
          // Energy is held on a failed round and reported as the score.
          w_pass2_nxt  = 1'b0;
          w_bonus2_nxt = 2'd0;
          w_score_nxt  = r_energy;
          w_state_nxt  = S_DONE;
        end else begin
          w_energy_nxt = w_round_energy;
          w_cnt_nxt    = r_cnt + CW'(1);
          if (w_last) begin
            w_pass2_nxt  = 1'b1;
            w_bonus2_nxt = bonus_of(w_round_energy);
            w_score_nxt  = w_round_energy;
            w_state_nxt  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (i_out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_energy <= 7'd0;
      r_cnt    <= '0;
      r_pass2  <= 1'b0;
      r_bonus2 <= 2'd0;
      r_score  <= 7'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_energy <= w_energy_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pass2  <= w_pass2_nxt;
      r_bonus2 <= w_bonus2_nxt;
      r_score  <= w_score_nxt;
    end
  end

endmodule

// File: tb/tb_stage2.sv
// Testbench for stage2: directed and random players, scoreboard queue plus
// a separate monitor that checks results, latency, stability and handshakes.
`timescale 1ns/1ps
module tb_stage2;
  localparam int ROUNDS     = 8;
  localparam int BONUS_STEP = 16;
  localparam int COST_BITS  = 4;
  localparam int W          = 10;

  typedef logic [6:0] rnd_t [ROUNDS];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_in_valid = 1'b0;
  logic       o_in_ready;
  logic       i_pass1 = 1'b0;
  logic [1:0] i_bonus1 = 2'd0;
  logic [6:0] i_stamina = 7'd0;
  logic [6:0] i_random2 = 7'd0;
  logic       o_out_valid;
  logic       i_out_ready = 1'b0;
  logic       o_pass2;
  logic [1:0] o_bonus2;
  logic [6:0] o_score;
  logic [1:0] o_dbg_state;

  logic [W-1:0] exp_q[$];
  time          exp_t_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  int           ready_mode = 0;
  bit           seen = 1'b0;
  bit           expect_idle = 1'b0;
  logic [W-1:0] cur_exp = '0;

  // clock / reset
  always #5 clk = ~clk;

  stage2 #(.ROUNDS(ROUNDS), .BONUS_STEP(BONUS_STEP), .COST_BITS(COST_BITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_pass1(i_pass1), .i_bonus1(i_bonus1), .i_stamina(i_stamina), .i_random2(i_random2),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_pass2(o_pass2), .o_bonus2(o_bonus2), .o_score(o_score), .o_dbg_state(o_dbg_state)
  );

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: result word {pass2, bonus2, score} and latency in cycles after accept.
  function automatic void model(input bit p1, input int b1, input int st, input rnd_t rnd,
                                output logic [W-1:0] res, output int lat);
    int e, c, mask;
    bit refund;
    mask = (1 << COST_BITS) - 1;
    res = '0;
    if (!p1) begin
      lat = 1;
      return;
    end
    e = st + b1 * BONUS_STEP;
    if (e > 127) e = 127;
    for (int k = 0; k < ROUNDS; k++) begin
      c = int'(rnd[k]) & mask;
      refund = 1'b0;
`ifdef STAGE2_REFUND_EN
      refund = rnd[k][6];
`endif
      if (refund) begin
        e = (e + c > 127) ? 127 : e + c;
      end else if (c > e) begin
        res = {1'b0, 2'd0, 7'(e)};
        lat = k + 2;
        return;
      end else begin
        e = e - c;
      end
    end
    res = {1'b1, 2'(e / 32), 7'(e)};
    lat = ROUNDS + 1;
  endfunction

  // out_ready changes just after the rising edge so the monitor sees it settled.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0)      i_out_ready = ($urandom_range(0, 3) != 0);
    else if (ready_mode == 1) i_out_ready = 1'b0;
    else                      i_out_ready = 1'b1;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
      expect_idle = 1'b0;
    end else begin
      if (expect_idle) begin
        chk(o_in_ready && !o_out_valid, "idle_after_handshake", int'({o_in_ready, o_out_valid}), 2);
        expect_idle = 1'b0;
      end
      if (o_out_valid) begin
        if (!seen) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_result", int'({o_pass2, o_bonus2, o_score}), -1);
            cur_exp = {o_pass2, o_bonus2, o_score};
          end else begin
            time et;
            cur_exp = exp_q.pop_front();
            et = exp_t_q.pop_front();
            chk(o_pass2 == cur_exp[9], "pass2", int'(o_pass2), int'(cur_exp[9]));
            chk(o_bonus2 == cur_exp[8:7], "bonus2", int'(o_bonus2), int'(cur_exp[8:7]));
            chk(o_score == cur_exp[6:0], "score", int'(o_score), int'(cur_exp[6:0]));
            chk(($time - 5) == et, "latency_edge", int'(($time - 5) / 10), int'(et / 10));
          end
          seen = 1'b1;
        end else begin
          chk({o_pass2, o_bonus2, o_score} == cur_exp, "held_stable",
              int'({o_pass2, o_bonus2, o_score}), int'(cur_exp));
        end
        chk(!o_in_ready, "in_ready_low_in_done", int'(o_in_ready), 0);
        if (i_out_ready) begin
          seen = 1'b0;
          expect_idle = 1'b1;
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!o_in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!o_in_ready) chk(1'b0, "in_ready_timeout", 0, 1);
  endtask

  task automatic accept(input bit p1, input int b1, input int st, input rnd_t rnd, input bit push);
    logic [W-1:0] res;
    int lat;
    wait_idle();
    i_in_valid = 1'b1;
    i_pass1 = p1;
    i_bonus1 = 2'(b1);
    i_stamina = 7'(st);
    i_random2 = 7'($urandom_range(0, 127));
    @(posedge clk);
    if (push) begin
      model(p1, b1, st, rnd, res, lat);
      exp_q.push_back(res);
      exp_t_q.push_back($time + (lat - 1) * 10);
    end
    @(negedge clk);
    i_in_valid = 1'b0;
    i_pass1 = 1'($urandom_range(0, 1));
    i_bonus1 = 2'($urandom_range(0, 3));
    i_stamina = 7'($urandom_range(0, 127));
  endtask

  task automatic drive_rounds(input rnd_t rnd, input int n);
    for (int k = 0; k < n; k++) begin
      i_random2 = rnd[k];
      @(negedge clk);
    end
    i_random2 = 7'($urandom_range(0, 127));
  endtask

  task automatic run_player(input bit p1, input int b1, input int st, input rnd_t rnd);
    accept(p1, b1, st, rnd, 1'b1);
    drive_rounds(rnd, ROUNDS);
  endtask

  task automatic fill(output rnd_t rnd, input logic [6:0] v);
    for (int k = 0; k < ROUNDS; k++) rnd[k] = v;
  endtask

  task automatic check_reset_vals(input string tag);
    chk(o_in_ready == 1'b1, {tag, "_in_ready"}, int'(o_in_ready), 1);
    chk(o_out_valid == 1'b0, {tag, "_out_valid"}, int'(o_out_valid), 0);
    chk(o_pass2 == 1'b0, {tag, "_pass2"}, int'(o_pass2), 0);
    chk(o_bonus2 == 2'd0, {tag, "_bonus2"}, int'(o_bonus2), 0);
    chk(o_score == 7'd0, {tag, "_score"}, int'(o_score), 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!o_out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_out_valid) chk(1'b0, "out_valid_timeout", 0, 1);
  endtask

  initial begin
    rnd_t rnd;
    int n;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // directed cases
    fill(rnd, 7'h00);
    run_player(1'b0, 3, 127, rnd);
    run_player(1'b1, 2, 100, rnd);
    fill(rnd, 7'h0F);
    run_player(1'b1, 0, 40, rnd);
    fill(rnd, 7'h01);
    run_player(1'b1, 0, 8, rnd);
    fill(rnd, 7'h0F);
    rnd[0] = 7'h4F;
    run_player(1'b1, 0, 10, rnd);

    // stalled result: in_valid pulses while held must be ignored
    ready_mode = 1;
    fill(rnd, 7'h00);
    run_player(1'b1, 2, 100, rnd);
    wait_valid();
    for (int k = 0; k < 3; k++) begin
      i_in_valid = 1'b1;
      i_pass1 = 1'b0;
      i_stamina = 7'($urandom_range(0, 127));
      if (k == 2) ready_mode = 2;
      @(negedge clk);
    end
    i_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    ready_mode = 0;

    // reset during RUN round 4 discards the player
    fill(rnd, 7'h00);
    accept(1'b1, 0, 127, rnd, 1'b0);
    drive_rounds(rnd, 3);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst_run");
    rst_n = 1'b1;

    // reset while a result is stalled in DONE
    ready_mode = 1;
    fill(rnd, 7'h02);
    run_player(1'b1, 1, 50, rnd);
    wait_valid();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst_done");
    rst_n = 1'b1;
    ready_mode = 0;

    // random players
    for (int p = 0; p < 40; p++) begin
      for (int k = 0; k < ROUNDS; k++) begin
        rnd[k] = 7'($urandom_range(0, 127));
        if ($urandom_range(0, 1) == 1) rnd[k] = rnd[k] & 7'h43;
      end
      run_player($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 127), rnd);
    end

    ready_mode = 2;
    n = 0;
    while ((exp_q.size() != 0 || o_out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk(1'b0, "drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
